// File: rtl/gerador_de_pulsos.sv
// gerador_de_pulsos: emits a burst of N_PULSOS clean pulses on line a, line b,
// or both, after a one-cycle start command. ocupado covers the whole burst and
// pronto strobes once in the first idle cycle after it.
module gerador_de_pulsos #(
  parameter int N_PULSOS   = 3,
  parameter int LARG_ALTO  = 1,
  parameter int LARG_BAIXO = 1,
  parameter int GAP_FIM    = 2,
  parameter int W_CNT      = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic sel,
  input  logic ambos,
  output logic a,
  output logic b,
  output logic ocupado,
  output logic pronto
);

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    ALTO   = 2'd1,
    BAIXO  = 2'd2,
    FIM    = 2'd3
  } estado_t;

  localparam logic [W_CNT-1:0] C_N     = W_CNT'(N_PULSOS);
  localparam logic [W_CNT-1:0] C_ALTO  = W_CNT'(LARG_ALTO);
  localparam logic [W_CNT-1:0] C_BAIXO = W_CNT'(LARG_BAIXO);
  localparam logic [W_CNT-1:0] C_FIM   = W_CNT'(GAP_FIM);

  estado_t          estado, prox;
  logic [W_CNT-1:0] wcnt;      // cycles spent in the current state, 1-based
  logic [W_CNT-1:0] pcnt;      // index of the pulse being generated, 1-based
  logic             sel_q, ambos_q;
  logic             sel_prox, ambos_prox;

  // Next-state logic; sel/ambos are captured only when a burst is launched.
  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    prox       = estado;
    sel_prox   = sel_q;
    ambos_prox = ambos_q;
    case (estado)
      OCIOSO: if (start) begin
        prox       = ALTO;
        sel_prox   = sel;
        ambos_prox = ambos;
      end
      ALTO:    if (wcnt == C_ALTO)  prox = (pcnt < C_N) ? BAIXO : FIM;
      BAIXO:   if (wcnt == C_BAIXO) prox = ALTO;
      FIM:     if (wcnt == C_FIM)   prox = OCIOSO;
      default: prox = OCIOSO;
    endcase
  end

  // State, counters and registered outputs, all updated on the same edge.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    if (reset) begin
      estado  <= OCIOSO;
      wcnt    <= '0;
      pcnt    <= '0;
      sel_q   <= 1'b0;
      ambos_q <= 1'b0;
      a       <= 1'b0;
      b       <= 1'b0;
      ocupado <= 1'b0;
      pronto  <= 1'b0;
    end else begin
      estado  <= prox;
      sel_q   <= sel_prox;
      ambos_q <= ambos_prox;

      // Width counter reloads on every state entry and rests at 0 while idle.
      if (prox != estado)       wcnt <= W_CNT'(1);
      else if (estado == OCIOSO) wcnt <= '0;
      else                       wcnt <= wcnt + W_CNT'(1);

      if (estado == OCIOSO && prox == ALTO)     pcnt <= W_CNT'(1);
      else if (estado == BAIXO && prox == ALTO) pcnt <= pcnt + W_CNT'(1);

      // Outputs are decoded from the next state so they line up with it.
      a       <= (prox == ALTO) && (ambos_prox || !sel_prox);
      b       <= (prox == ALTO) && (ambos_prox ||  sel_prox);
      ocupado <= (prox != OCIOSO);
      pronto  <= (estado == FIM) && (prox == OCIOSO);
    end
  end

endmodule

// File: tb/tb_gerador_de_pulsos.sv
// Bench for gerador_de_pulsos: a default instance and an overridden instance
// share random stimulus and are compared every cycle against a model that
// derives each output from the cycle offset within the burst.
module tb_gerador_de_pulsos;

  logic clk = 1'b0;
  logic reset, start, sel, ambos;
  logic a0, b0, o0, p0;
  logic a1, b1, o1, p1;

  int total = 0;
  int bad   = 0;

  // Model state: cycle offset inside a burst (0 = idle) and latched selects.
  int   t0 = 0, t1 = 0;
  logic s0 = 1'b0, m0 = 1'b0, s1 = 1'b0, m1 = 1'b0;
  int   cyc = 0;

  localparam int L0 = 3*1 + 2*1 + 2;   // default burst length
  localparam int L1 = 5*3 + 4*2 + 4;   // override burst length

  always #5 clk = ~clk;

  gerador_de_pulsos u_def (
    .clk(clk), .reset(reset), .start(start), .sel(sel), .ambos(ambos),
    .a(a0), .b(b0), .ocupado(o0), .pronto(p0)
  );

  gerador_de_pulsos #(
    .N_PULSOS(5), .LARG_ALTO(3), .LARG_BAIXO(2), .GAP_FIM(4), .W_CNT(4)
  ) u_ovr (
    .clk(clk), .reset(reset), .start(start), .sel(sel), .ambos(ambos),
    .a(a1), .b(b1), .ocupado(o1), .pronto(p1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  // Expected {a,b,ocupado,pronto} at offset t of a burst.
  function automatic logic [3:0] model_out(input int t, input logic s, input logic am,
                                           input int n, input int la, input int lb, input int gf);
    int  hi_len;
    logic line;
    hi_len = n*la + (n-1)*lb;
    if (t == 0) return 4'b0000;
    if (t <= hi_len) begin
      line = ((t-1) % (la+lb)) < la;
      return {line & (am | ~s), line & (am | s), 1'b1, 1'b0};
    end
    if (t <= hi_len + gf) return 4'b0010;
    if (t == hi_len + gf + 1) return 4'b0001;
    return 4'b0000;
  endfunction

  // Offset after the edge: a start is taken when idle or in the pronto cycle.
  function automatic int next_t(input int t, input int len, input logic rst, input logic st);
    if (rst) return 0;
    if ((t == 0 || t == len + 1) && st) return 1;
    if (t != 0 && t <= len) return t + 1;
    return 0;
  endfunction

  // One clock: advance the model at the edge, compare both DUTs mid-cycle.
  task automatic tick();
    @(posedge clk);
    if (!reset && (t0 == 0 || t0 == L0 + 1) && start) begin s0 = sel; m0 = ambos; end
    if (!reset && (t1 == 0 || t1 == L1 + 1) && start) begin s1 = sel; m1 = ambos; end
    t0 = next_t(t0, L0, reset, start);
    t1 = next_t(t1, L1, reset, start);
    cyc++;
    @(negedge clk);
    check("def", {a0, b0, o0, p0}, model_out(t0, s0, m0, 3, 1, 1, 2));
    check("ovr", {a1, b1, o1, p1}, model_out(t1, s1, m1, 5, 3, 2, 4));
  endtask

  task automatic idle_cycles(input int n);
    start = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  logic [7:0] a_tab, o_tab, p_tab;
  logic [27:0] b6_tab;

  initial begin
    reset = 1'b1; start = 1'b0; sel = 1'b0; ambos = 1'b0;
    tick(); tick();
    check("reset_state", {a0, b0, o0, p0, a1, b1, o1, p1}, 8'h00);
    reset = 1'b0;
    idle_cycles(2);

    // Single-line burst on a with fixed expectations: cycles 1..8.
    a_tab = 8'b0001_0101;  // bit k-1 = cycle k
    o_tab = 8'b0111_1111;
    p_tab = 8'b1000_0000;
    cyc = 0;
    start = 1'b1; sel = 1'b0; ambos = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      start = 1'b0;
      check("t2_a", a0, a_tab[k-1]);
      check("t2_b", b0, 1'b0);
      check("t2_ocupado", o0, o_tab[k-1]);
      check("t2_pronto", p0, p_tab[k-1]);
    end
    idle_cycles(30);

    // Reset at the edge after the second pulse; no pronto may follow.
    start = 1'b1; sel = 1'b0;
    tick(); start = 1'b0; tick(); tick();
    check("t1_second_pulse", a0, 1'b1);
    reset = 1'b1; tick(); reset = 1'b0;
    check("t1_abort", {a0, b0, o0, p0}, 4'b0000);
    for (int k = 0; k < 10; k++) begin
      tick();
      check("t1_no_pronto", {o0, p0}, 2'b00);
    end
    idle_cycles(20);

    // Start re-asserted during a burst is ignored; start in the pronto cycle is taken.
    cyc = 0;
    start = 1'b1; sel = 1'b0; tick();
    for (int k = 2; k <= 7; k++) begin
      start = 1'b1; sel = k[0]; tick();
      check("t5_a_only", b0, 1'b0);
    end
    start = 1'b0; tick();
    check("t5_pronto", p0, 1'b1);
    start = 1'b1; sel = 1'b1;
    for (int k = 9; k <= 13; k++) begin
      tick(); start = 1'b0;
      check("t5_b", {a0, b0}, {1'b0, k[0]});
    end
    idle_cycles(30);

    // Both lines at once.
    start = 1'b1; sel = 1'b0; ambos = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick(); start = 1'b0;
      check("t4_ab", {a0, b0}, {2{k[0]}});
    end
    ambos = 1'b0;
    idle_cycles(30);

    // Overridden instance, fixed pattern on b for cycles 1..28.
    b6_tab = 28'b0000_0111_0011_1001_1100_1110_0111;  // bit k-1 = cycle k
    cyc = 0;
    start = 1'b1; sel = 1'b1;
    for (int k = 1; k <= 28; k++) begin
      tick(); start = 1'b0;
      check("t6_b", b1, b6_tab[k-1]);
      check("t6_ocupado", o1, (k <= 27) ? 1'b1 : 1'b0);
      check("t6_pronto", p1, (k == 28) ? 1'b1 : 1'b0);
    end
    idle_cycles(5);

    // Random stimulus against the model.
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 3) == 0);
      sel   = 1'($urandom_range(0, 1));
      ambos = ($urandom_range(0, 3) == 0);
      reset = ($urandom_range(0, 59) == 0);
      tick();
    end
    reset = 1'b0;
    idle_cycles(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
